// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, instruction-cycle phases, widths.
package cpu_controller_pkg;

  localparam int OPCODE_WIDTH = 3;
  localparam int PHASE_WIDTH  = 3;
  localparam int DATA_WIDTH   = 8;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'b111;

  // One phase per clock, eight phases per instruction, wrapping STORE -> INST_ADDR.
  typedef enum logic [PHASE_WIDTH-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Sequencing controller: 8-phase instruction cycle counter with a sticky halt,
// decoding phase/opcode/zero into the datapath strobes.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    halt,
  output logic                    data_e,
  output logic                    ld_ac,
  output logic                    wr
);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  assign aluop = is_aluop(opcode);

  // State register: phase counter and halted flag, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and strobe decode. Halt is set on the OP_ADDR edge of HLT, which
  // also advances the phase to OP_FETCH, where it then stays frozen.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    halt     = 1'b0;
    data_e   = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;

    if (!halted_q) begin
      phase_d = phase_e'(phase_q + 1'b1);
      if (phase_q == PH_OP_ADDR && opcode == OP_HLT) halted_d = 1'b1;
    end

    // Reset masks every strobe so an abandoned instruction issues nothing.
    if (rst) begin
      halt = 1'b0;
    end else if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        PH_INST_ADDR:  sel = 1'b1;
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR:  inc_pc = 1'b1;
        PH_OP_FETCH: rd = aluop;
        PH_ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench: each cycle the expected strobe vector is derived from the
// phase table and pushed when inputs are driven, then popped and compared mid-cycle.
module tb_cpu_controller;
  import cpu_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         m_ph;
  bit         m_halted;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .halt(halt), .data_e(data_e), .ld_ac(ld_ac), .wr(wr)
  );

  always #5 clk = ~clk;

  // Order: {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}
  function automatic logic [8:0] expect_out(input bit r, input int ph, input bit h,
                                            input logic [2:0] op, input logic z);
    bit alu, sto, jmp;
    alu = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    sto = (op == 3'b110);
    jmp = (op == 3'b111);
    if (r) return 9'b0;
    if (h) return 9'b000001000;
    case (ph)
      0: return 9'b100000000;
      1: return 9'b110000000;
      2: return 9'b111000000;
      3: return 9'b111000000;
      4: return 9'b000100000;
      5: return {1'b0, alu, 7'b0};
      6: return {1'b0, alu, 1'b0, (op == 3'b001) && (z == 1'b1), jmp, 1'b0, sto, 2'b0};
      default: return {1'b0, alu, 2'b0, jmp, 1'b0, sto, alu, sto};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr)",
               tag, got, exp);
    end
  endtask

  // One clock: drive inputs, push expectation, compare at negedge, advance model.
  task automatic step(input bit r, input logic [2:0] op, input logic z);
    logic [8:0] got;
    logic [8:0] exp;
    string tag;
    rst = r; opcode = op; zero = z;
    exp_q.push_back(expect_out(r, m_ph, m_halted, op, z));
    tag = $sformatf("ph%0d op%03b z%0b rst%0b halted%0b", m_ph, op, z, r, m_halted);
    @(negedge clk);
    got = {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %s", tag);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, got, exp);
    end
    if (ld_ac && wr) chk("ld_ac_wr_exclusive", 9'd1, 9'd0);
    @(posedge clk);
    if (r) begin
      m_ph = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (m_ph == 4 && op == 3'b000) m_halted = 1;
      m_ph = (m_ph + 1) % 8;
    end
    #1;
  endtask

  task automatic instr(input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) step(0, op, z);
  endtask

  initial begin
    m_ph = 0; m_halted = 0;
    rst = 1; opcode = 3'b000; zero = 0;
    @(posedge clk); #1;
    // Reset held: strobes masked even with an opcode present.
    step(1, OP_STO, 0);
    step(1, OP_ADD, 1);
    // One instruction of each non-halting opcode, zero both ways where it matters.
    instr(OP_ADD, 0);
    instr(OP_ADD, 1);
    instr(OP_STO, 0);
    instr(OP_SKZ, 1);
    instr(OP_SKZ, 0);
    instr(OP_JMP, 0);
    instr(OP_AND, 1);
    instr(OP_XOR, 0);
    instr(OP_LDA, 1);
    // Reset during ALU_OP of STO: no wr/ld_ac, restart at INST_ADDR.
    for (int i = 0; i < 6; i++) step(0, OP_STO, 0);
    step(1, OP_STO, 0);
    instr(OP_STO, 1);
    // Random opcodes, zero held per instruction.
    for (int k = 0; k < 6; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(1, 7));
      instr(op, 1'($urandom_range(0, 1)));
    end
    // HLT: OP_ADDR still increments PC, then halt frozen for 20+ cycles.
    instr(OP_HLT, 0);
    for (int i = 0; i < 20; i++) step(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    // Single-cycle reset clears halt and restarts the cycle.
    step(1, OP_HLT, 0);
    instr(OP_ADD, 0);
    instr(OP_JMP, 1);
    if (exp_q.size() != 0) chk("scoreboard_drained", 9'(exp_q.size()), 9'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
